eth_ocm_mem_arb: RTL

- Shares one external Avalon-MM memory master port between the Ethernet MAC's RX DMA write master and TX DMA read master.
- Sits between the MAC's av_rx_* / av_tx_* masters and the system interconnect, so the MAC needs only one memory port.
- Grant is registered; RX is favoured on contention, with a bounded-burst fairness rule.
- Outstanding TX reads are tracked and throttled.

---
 rtl/eth_ocm_mem_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/eth_ocm_mem_arb.sv
// eth_ocm_mem_arb: shares one Avalon-MM master port between the MAC's RX DMA
// write master and TX DMA read master. Registered grant, RX favoured on
// contention, bounded-burst fairness, and throttling of outstanding TX reads.
// Optional stall statistics are compiled in with ETH_OCM_ARB_STATS_EN.
module eth_ocm_mem_arb #(
  parameter int unsigned ADDR_W            = 32,
  parameter int unsigned RX_HOLD_BEATS     = 4,
  parameter int unsigned MAX_PENDING_READS = 4
) (
  input  logic              av_clk,
  input  logic              av_reset_n,
  input  logic [ADDR_W-1:0] rx_address,
  input  logic              rx_write,
  input  logic [31:0]       rx_writedata,
  input  logic [3:0]        rx_byteenable,
  output logic              rx_waitrequest,
  input  logic [ADDR_W-1:0] tx_address,
  input  logic              tx_read,
  output logic              tx_waitrequest,
  output logic [31:0]       tx_readdata,
  output logic              tx_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid
`ifdef ETH_OCM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_rx_stall,
  output logic [15:0]       stat_tx_stall
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT_RX, GRANT_TX} state_t;

  localparam logic [3:0] HOLD = 4'(RX_HOLD_BEATS);
  localparam logic [3:0] MAXP = 4'(MAX_PENDING_READS);

  state_t     state, state_nxt;
  logic [3:0] beat_cnt, beat_nxt;
  logic [3:0] pend_cnt;
  logic       rd_full;
  logic       tx_req;
  logic       accept;
  logic       rd_acc;
  logic       hold_done;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] clamp_dec4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  assign rd_full   = (pend_cnt == MAXP);
  assign tx_req    = tx_read & ~rd_full;
  assign accept    = (m_read | m_write) & ~m_waitrequest;
  assign rd_acc    = m_read & ~m_waitrequest;
  // Saturated counts (>=) still hand over once the other side starts asking.
  assign hold_done = accept & (({1'b0, beat_cnt} + 5'd1) >= {1'b0, HOLD});

  // Read data is passed straight through regardless of which side holds the grant.
  assign tx_readdata      = m_readdata;
  assign tx_readdatavalid = m_readdatavalid;

  // Master-side mux and waitrequests driven from the registered grant.
  always_comb begin
    m_address      = '0;
    m_writedata    = '0;
    m_byteenable   = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    rx_waitrequest = 1'b1;
    tx_waitrequest = 1'b1;
    case (state)
      GRANT_RX: begin
        m_address      = rx_address;
        m_writedata    = rx_writedata;
        m_byteenable   = rx_byteenable;
        m_write        = rx_write;
        rx_waitrequest = m_waitrequest;
      end
      GRANT_TX: begin
        m_address      = tx_address;
        m_byteenable   = 4'hF;
        m_read         = tx_req;
        tx_waitrequest = rd_full | m_waitrequest;
      end
      default: ;
    endcase
  end

  // Next grant and beat count: RX wins ties, the holder yields after its burst budget.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_write)    state_nxt = GRANT_RX;
        else if (tx_req) state_nxt = GRANT_TX;
      end
      GRANT_RX: begin
        if (!rx_write || (hold_done && tx_req))
          state_nxt = tx_req ? GRANT_TX : IDLE;
      end
      GRANT_TX: begin
        // A throttled TX keeps the grant only if RX has nothing to send.
        if (!tx_req || (hold_done && rx_write))
          state_nxt = rx_write ? GRANT_RX : (tx_read ? GRANT_TX : IDLE);
      end
      default: state_nxt = IDLE;
    endcase

    beat_nxt = beat_cnt;
    if (state_nxt != state || state_nxt == IDLE) beat_nxt = 4'd0;
    else if (accept)                             beat_nxt = sat_inc4(beat_cnt, HOLD);
  end

  // Grant state and beat counter registers.
  always_ff @(posedge av_clk) begin
    if (!av_reset_n) begin
      state    <= IDLE;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Outstanding read tracker; a return after reset never underflows.
  always_ff @(posedge av_clk) begin
    if (!av_reset_n) begin
      pend_cnt <= 4'd0;
    end else if (rd_acc && !m_readdatavalid) begin
      pend_cnt <= sat_inc4(pend_cnt, 4'hF);
    end else if (!rd_acc && m_readdatavalid) begin
      pend_cnt <= clamp_dec4(pend_cnt);
    end
  end

`ifdef ETH_OCM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stall-cycle statistics; clear takes priority over counting.
  always_ff @(posedge av_clk) begin
    if (!av_reset_n || stat_clr) begin
      stat_rx_stall <= 16'd0;
      stat_tx_stall <= 16'd0;
    end else begin
      if (rx_write && rx_waitrequest) stat_rx_stall <= sat_inc16(stat_rx_stall);
      if (tx_read && tx_waitrequest)  stat_tx_stall <= sat_inc16(stat_tx_stall);
    end
  end
`endif

endmodule
